// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event front-end.
// Pure declarations: no latency, no flow control.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    LONG,
    DEB_RELEASE
  } key_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Raw button inputs and classified key events between board and watch logic.
// Wires only: no latency, no backpressure (events are fire-and-forget).
interface key_event_gen_if;
  logic key_raw_1;
  logic key_raw_2;
  logic key_first_1;
  logic key_first_2;
  logic key_long_1;
  logic key_long_2;

  modport master (
    output key_raw_1, key_raw_2,
    input  key_first_1, key_first_2, key_long_1, key_long_2
  );

  modport slave (
    input  key_raw_1, key_raw_2,
    output key_first_1, key_first_2, key_long_1, key_long_2
  );
endinterface

// File: rtl/key_channel.sv
// One button: 2-flop sync, debounce FSM with ms counter, registered first/long events.
// Press latency 3 cycles + DEBOUNCE_MS (-1 tick); no backpressure, outputs free-running.
module key_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic tick,
  output logic first,
  output logic long
);

  localparam int            CW       = $clog2(LONG_MS + 1);
  localparam logic [CW-1:0] DEB_CNT  = CW'(DEBOUNCE_MS);
  localparam logic [CW-1:0] LONG_CNT = CW'(LONG_MS);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic          RELEASED = (KEY_ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic          pressed;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          first_d, long_d;

  // Sync flops reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {2{RELEASED}};
    end else begin
      sync_q <= {sync_q[0], key_raw};
    end
  end

  assign pressed = (sync_q[1] != RELEASED);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pressed) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_inc == DEB_CNT) state_d = PRESSED;
          else                    cnt_d   = cnt_inc;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = DEB_RELEASE;
        end else if (tick) begin
          if (cnt_inc == LONG_CNT) state_d = LONG;
          else                     cnt_d   = cnt_inc;
        end
      end
      LONG: begin
        if (!pressed) state_d = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        // A bounce back to pressed restarts the release window; it never re-arms a press.
        if (pressed) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_inc == DEB_CNT) state_d = IDLE;
          else                    cnt_d   = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    first_d = (state_q == DEB_PRESS) && (state_d == PRESSED);
    long_d  = (state_d == LONG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first   <= 1'b0;
      long    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first   <= first_d;
      long    <= long_d;
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Two-key front-end: shared 1 ms tick prescaler feeding two independent key channels.
// Event latency is that of key_channel; no backpressure, both keys report without arbitration.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int IN_CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  key_event_gen_if.slave  keys
);

  localparam int TICK_DIV = int'(ms_to_cycles(IN_CLK_HZ, 1));
  localparam int PW       = $clog2(TICK_DIV);

  if (LONG_MS <= DEBOUNCE_MS || DEBOUNCE_MS == 0) begin : g_bad_timing
    $error("key_event_gen: need DEBOUNCE_MS > 0 and LONG_MS > DEBOUNCE_MS");
  end
  if (TICK_DIV < 2) begin : g_bad_clk
    $error("key_event_gen: IN_CLK_HZ must give at least 2 cycles per ms");
  end

  logic [PW-1:0] presc_q;
  logic          tick;

  // Free-running, so the first ms after any press can be up to one tick short.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  key_channel #(
    .DEBOUNCE_MS   (DEBOUNCE_MS),
    .LONG_MS       (LONG_MS),
    .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
  ) u_key_1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(keys.key_raw_1),
    .tick   (tick),
    .first  (keys.key_first_1),
    .long   (keys.key_long_1)
  );

  key_channel #(
    .DEBOUNCE_MS   (DEBOUNCE_MS),
    .LONG_MS       (LONG_MS),
    .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
  ) u_key_2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(keys.key_raw_2),
    .tick   (tick),
    .first  (keys.key_first_2),
    .long   (keys.key_long_2)
  );

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen at 10 cycles/ms, DEBOUNCE_MS=3, LONG_MS=10.
module tb_key_event_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic mon_clr;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_gen_if kif ();

  key_event_gen #(
    .IN_CLK_HZ     (10_000),
    .DEBOUNCE_MS   (3),
    .LONG_MS       (10),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .keys (kif)
  );

  // Event monitor, sampled on the falling edge.
  int   first_cnt [2];
  int   first_cyc [2];
  int   long_rise [2];
  int   long_fall [2];
  logic long_seen [2];
  logic long_prev [2];
  logic [1:0] first_v, long_v;

  assign first_v = {kif.key_first_2, kif.key_first_1};
  assign long_v  = {kif.key_long_2, kif.key_long_1};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mon_clr) begin
        first_cnt[k] <= 0;
        first_cyc[k] <= -1;
        long_rise[k] <= -1;
        long_fall[k] <= -1;
        long_seen[k] <= 1'b0;
        long_prev[k] <= 1'b0;
      end else begin
        if (first_v[k]) begin
          first_cnt[k] <= first_cnt[k] + 1;
          if (first_cyc[k] < 0) first_cyc[k] <= cyc;
        end
        if (long_v[k]) long_seen[k] <= 1'b1;
        if (long_v[k] && !long_prev[k]) long_rise[k] <= cyc;
        if (!long_v[k] && long_prev[k]) long_fall[k] <= cyc;
        long_prev[k] <= long_v[k];
      end
    end
  end

  typedef struct {
    logic [1:0] keys;       // bit0 = key 1, bit1 = key 2
    int         bounce;     // cycles of 4-cycle toggling before the steady press
    int         hold;       // steady press length in cycles
    int         rel_bounce; // cycles of 4-cycle toggling after release
    int         exp_first;  // key_first pulses expected per pressed key
    logic       exp_long;   // key_long expected per pressed key
    int         lat_lo;     // key_first latency window from the first press drive
    int         lat_hi;
  } vec_t;

  vec_t vecs [5];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_keys(input logic [1:0] mask, input logic down);
    kif.key_raw_1 = ~(mask[0] & down);
    kif.key_raw_2 = ~(mask[1] & down);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      if (lo == hi) $display("FAIL %s: got %0d, want %0d", nm, act, lo);
      else          $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  initial begin
    int   t_press, t_rel, t_rst;
    vec_t v;

    // Clean press; bouncy press/release (steady press starts 16 cycles in);
    // long hold on key 2; 15-cycle glitch; both keys together.
    vecs[0] = '{keys: 2'b01, bounce: 0,  hold: 60,  rel_bounce: 0,  exp_first: 1, exp_long: 1'b0, lat_lo: 22, lat_hi: 34};
    vecs[1] = '{keys: 2'b01, bounce: 20, hold: 60,  rel_bounce: 20, exp_first: 1, exp_long: 1'b0, lat_lo: 38, lat_hi: 50};
    vecs[2] = '{keys: 2'b10, bounce: 0,  hold: 250, rel_bounce: 0,  exp_first: 1, exp_long: 1'b1, lat_lo: 22, lat_hi: 34};
    vecs[3] = '{keys: 2'b01, bounce: 0,  hold: 15,  rel_bounce: 0,  exp_first: 0, exp_long: 1'b0, lat_lo: 0,  lat_hi: 0};
    vecs[4] = '{keys: 2'b11, bounce: 0,  hold: 60,  rel_bounce: 0,  exp_first: 1, exp_long: 1'b0, lat_lo: 22, lat_hi: 34};

    mon_clr = 1'b1;
    rst_n   = 1'b0;
    set_keys(2'b11, 1'b0);
    step(3);
    chk("reset key_first_1", int'(kif.key_first_1), 0, 0);
    chk("reset key_first_2", int'(kif.key_first_2), 0, 0);
    chk("reset key_long_1",  int'(kif.key_long_1),  0, 0);
    chk("reset key_long_2",  int'(kif.key_long_2),  0, 0);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      clear_mon();
      t_press = cyc;
      for (int c = 0; c < v.bounce; c++) begin
        set_keys(v.keys, ((c / 4) % 2) == 0);
        step(1);
      end
      set_keys(v.keys, 1'b1);
      step(v.hold);
      t_rel = cyc;
      for (int c = 0; c < v.rel_bounce; c++) begin
        set_keys(v.keys, ((c / 4) % 2) == 1);
        step(1);
      end
      set_keys(v.keys, 1'b0);
      step(80);

      for (int k = 0; k < 2; k++) begin
        chk($sformatf("v%0d key%0d first count", i, k + 1), first_cnt[k],
            v.keys[k] ? v.exp_first : 0, v.keys[k] ? v.exp_first : 0);
        chk($sformatf("v%0d key%0d long seen", i, k + 1), int'(long_seen[k]),
            int'(v.keys[k] & v.exp_long), int'(v.keys[k] & v.exp_long));
        if (v.keys[k] && v.exp_first > 0)
          chk($sformatf("v%0d key%0d first latency", i, k + 1), first_cyc[k] - t_press,
              v.lat_lo, v.lat_hi);
        if (v.keys[k] && v.exp_long) begin
          chk($sformatf("v%0d key%0d long rise after first", i, k + 1),
              long_rise[k] - first_cyc[k], 90, 110);
          chk($sformatf("v%0d key%0d long fall after release", i, k + 1),
              long_fall[k] - t_rel, 3, 3);
        end
      end
      if (v.keys == 2'b11)
        chk($sformatf("v%0d same-cycle first", i), first_cyc[1] - first_cyc[0], 0, 0);
    end

    // Reset while key 1 is in LONG, key kept held through and after reset.
    clear_mon();
    set_keys(2'b01, 1'b1);
    step(150);
    chk("pre-reset key_long_1", int'(kif.key_long_1), 1, 1);
    rst_n = 1'b0;
    step(1);
    chk("reset drops key_long_1", int'(kif.key_long_1), 0, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mon_clr = 1'b1;
    t_rst   = cyc;
    @(posedge clk);
    #1 mon_clr = 1'b0;
    step(60);
    chk("post-reset first count", first_cnt[0], 1, 1);
    chk("post-reset first latency", first_cyc[0] - t_rst, 30, 40);
    chk("post-reset key2 quiet", first_cnt[1], 0, 0);
    set_keys(2'b01, 1'b0);
    step(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
